wb_commit_unit: RTL
===================

// Module: wb_commit_unit
// PURPOSE
// - Consumer end of the MEM/WB pipeline register: turns wb_* fields into the register-file write port and the CSR write port.
// - Keeps the 64-bit minstret counter and a one-cycle write-hold bypass for the decode-stage read ports.
// - Optional commit-trace FIFO for the debug sink.
// PARAMETERS
// - XLEN         32  datapath width; equals `ARCH_WIDTH / `DATA_WIDTH from common.vh
// - TRACE_DEPTH  8   trace FIFO entries; power of two, >=2; used only with COMMIT_TRACE_EN
// PORTS
// - clk              in   1     clock; single clock domain
// - rst              in   1     synchronous, active-high reset
// - wb_valid         in   1     WB holds a real instruction this cycle; 0 = bubble/flushed slot
// - wb_reg_file_we   in   1     rd write request
// - wb_reg_file_rd   in   5     destination register
// - wb_reg_file_sel  in   2     0=alu_res 1=data_mem_out 2=pc_out+4 3=csr_rdata
// - wb_alu_res       in   XLEN  ALU result
// - wb_data_mem_out  in   XLEN  load data, already extended
// - wb_pc_out        in   XLEN  PC of the WB instruction
// - wb_rs1           in   5     rs1 index; zimm for the immediate CSR forms
// - wb_csr_src       in   3     1=RW 2=RS 3=RC 5=RWI 6=RSI 7=RCI; 0/4 = no CSR op
// - wb_csr_addr      in   12    CSR address
// - wb_csr_we        in   1     instruction is a CSR op
// - wb_csr_data_out  in   XLEN  rs1 value
// - csr_rdata        in   XLEN  current CSR value at wb_csr_addr (combinational read)
// - wb_instr         in   32    instruction word (trace only)
// - rf_we/rf_waddr/rf_wdata  out 1/5/XLEN   register-file write port
// - csr_we/csr_waddr/csr_wdata out 1/12/XLEN CSR write port
// - hold_we/hold_rd/hold_data out 1/5/XLEN  last cycle's rf write, for decode bypass
// - minstret         out  64    retired-instruction count
// - trace_valid/trace_ready out/in 1/1    trace handshake (COMMIT_TRACE_EN)
// - trace_data       out  109   {pc[31:0], instr[31:0], rd[4:0], wdata[31:0], we, 7'b0}
// - trace_overflow   out  1     sticky: entry dropped while FIFO full
// BEHAVIOUR
// - Reset: every output 0. Trace FIFO is emptied and trace_overflow cleared.
// - rf_we = wb_valid & wb_reg_file_we & (rd!=0). rf_wdata is muxed by sel. All combinational, zero latency.
// - Source operand: src = csr_src[2] ? {27'b0,wb_rs1} : wb_csr_data_out.
// - csr_wdata: RW=src; RS=csr_rdata|src; RC=csr_rdata&~src.
// - csr_we = wb_valid & wb_csr_we & op valid, except RS/RC with src index 0 (rs1==x0 or zimm==0), which do not write.
// - Hold register: on each posedge, hold_* <= current rf_we/rf_waddr/rf_wdata; it updates every cycle, including bubbles.
// - minstret: +1 per cycle with wb_valid; 64-bit wrap FFFF_FFFF_FFFF_FFFF -> 0.
// - A CSR write to 0xB02 replaces the low word; a write to 0xB82 replaces the high word. The write wins over the increment in that cycle (no +1).
// - rst in mid-operation drops all in-flight state in the same edge. No partial trace entry is kept.
// CONFIGURATION
// - COMMIT_TRACE_EN defined:
//   - every wb_valid cycle pushes one entry; pop on trace_valid&trace_ready.
//   - push and pop in the same cycle while full is accepted (count unchanged).
//   - push while full with no pop drops the entry and sets trace_overflow until rst.
//   - pointers wrap modulo TRACE_DEPTH.
// - COMMIT_TRACE_EN undefined: no FIFO logic; trace_valid=0, trace_data=0, trace_overflow=0; trace_ready ignored.
// STRUCTURE
// - common.vh holds the shared constants: WB_SEL_{ALU,MEM,PC4,CSR}, CSR_OP_* encodings, CSR_MINSTRET/CSR_MINSTRETH addresses.
// - One sub-module: commit_trace_fifo (sync FIFO, depth/width params), instantiated only under COMMIT_TRACE_EN.
// TESTING
// - sel=2, pc=0x80, rd=5, valid=1 -> rf_we=1, rf_wdata=0x84. Next cycle hold_rd=5, hold_data=0x84.
// - rd=0, we=1 -> rf_we=0. Bubble (valid=0) with we=1 -> rf_we=0 and minstret unchanged.
// - CSRRS, rs1=x0, csr_rdata=0xF0 -> csr_we=0. CSRRCI zimm=0x3, rdata=0xFF -> csr_we=1, wdata=0xFC.
// - minstret=0x0000_0000_FFFF_FFFF, valid -> 0x0000_0001_0000_0000. CSRRW 0xB02=0x10 while valid -> low word 0x10, no increment.
// - [COMMIT_TRACE_EN, DEPTH 8] trace_ready=0, 9 valid commits -> 8 entries held, trace_overflow=1. Then ready=1 drains 8 in order.
// - rst asserted mid-stream -> next cycle all outputs 0, trace_valid=0, minstret=0.

Source files
------------

// File: rtl/wb_commit_unit_pkg.sv
// Shared encodings for the write-back commit slice: result-select and CSR op codes, minstret CSR addresses,
// and the packed layout of one commit-trace entry.
package wb_commit_unit_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_CSR = 2'd3
    } wb_sel_e;

    // Low two bits of csr_src; bit 2 selects the zimm operand form.
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        we;
        logic [6:0]  pad;
    } trace_entry_t;

    localparam int TRACE_W = $bits(trace_entry_t);

endpackage

// File: rtl/wb_commit_unit_commit_trace_fifo.sv
// Synchronous FIFO holding commit-trace entries for the debug sink.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: none upstream; a push while full with no pop is dropped and flags sticky overflow.
module commit_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 109
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = !empty && pop_ready;
    // A pop frees the slot in the same edge, so a full FIFO still accepts a concurrent push.
    assign wr    = push && (!full || pop);

    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit: register-file and CSR write ports, minstret, decode bypass hold, optional trace (COMMIT_TRACE_EN).
// Latency: write ports are combinational from wb_*; hold_* and minstret update on the following edge.
// Backpressure: none on the pipeline; trace entries that find the FIFO full are dropped and flagged.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_valid,
    input  logic               wb_reg_file_we,
    input  logic [4:0]         wb_reg_file_rd,
    input  logic [1:0]         wb_reg_file_sel,
    input  logic [XLEN-1:0]    wb_alu_res,
    input  logic [XLEN-1:0]    wb_data_mem_out,
    input  logic [XLEN-1:0]    wb_pc_out,
    input  logic [4:0]         wb_rs1,
    input  logic [2:0]         wb_csr_src,
    input  logic [11:0]        wb_csr_addr,
    input  logic               wb_csr_we,
    input  logic [XLEN-1:0]    wb_csr_data_out,
    input  logic [XLEN-1:0]    csr_rdata,
    input  logic [31:0]        wb_instr,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               csr_we,
    output logic [11:0]        csr_waddr,
    output logic [XLEN-1:0]    csr_wdata,
    output logic               hold_we,
    output logic [4:0]         hold_rd,
    output logic [XLEN-1:0]    hold_data,
    output logic [63:0]        minstret,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [TRACE_W-1:0] trace_data,
    output logic               trace_overflow
);

    logic            rf_we_c;
    logic [XLEN-1:0] rf_wdata_c;
    logic            csr_we_c;
    logic            csr_op_writes;
    logic [XLEN-1:0] csr_src_val;
    logic [XLEN-1:0] csr_wdata_c;

    always_comb begin
        rf_we_c    = wb_valid && wb_reg_file_we && (wb_reg_file_rd != 5'd0);
        rf_wdata_c = '0;
        case (wb_sel_e'(wb_reg_file_sel))
            WB_SEL_ALU: rf_wdata_c = wb_alu_res;
            WB_SEL_MEM: rf_wdata_c = wb_data_mem_out;
            WB_SEL_PC4: rf_wdata_c = wb_pc_out + XLEN'(4);
            WB_SEL_CSR: rf_wdata_c = csr_rdata;
            default:    rf_wdata_c = '0;
        endcase
    end

    // Set/clear with a zero source index is a pure read and must not write the CSR.
    always_comb begin
        csr_src_val   = wb_csr_src[2] ? XLEN'(wb_rs1) : wb_csr_data_out;
        csr_wdata_c   = '0;
        csr_op_writes = 1'b0;
        case (csr_op_e'(wb_csr_src[1:0]))
            CSR_OP_RW: begin
                csr_wdata_c   = csr_src_val;
                csr_op_writes = 1'b1;
            end
            CSR_OP_RS: begin
                csr_wdata_c   = csr_rdata | csr_src_val;
                csr_op_writes = (wb_rs1 != 5'd0);
            end
            CSR_OP_RC: begin
                csr_wdata_c   = csr_rdata & ~csr_src_val;
                csr_op_writes = (wb_rs1 != 5'd0);
            end
            default: ;
        endcase
        csr_we_c = wb_valid && wb_csr_we && csr_op_writes;
    end

    assign rf_we     = !rst && rf_we_c;
    assign rf_waddr  = rst ? 5'd0 : wb_reg_file_rd;
    assign rf_wdata  = rst ? '0 : rf_wdata_c;
    assign csr_we    = !rst && csr_we_c;
    assign csr_waddr = rst ? 12'd0 : wb_csr_addr;
    assign csr_wdata = rst ? '0 : csr_wdata_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_we   <= 1'b0;
            hold_rd   <= 5'd0;
            hold_data <= '0;
        end else begin
            hold_we   <= rf_we_c;
            hold_rd   <= wb_reg_file_rd;
            hold_data <= rf_wdata_c;
        end
    end

    // A software write to either half takes priority over the retire increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            minstret <= 64'd0;
        end else if (csr_we_c && wb_csr_addr == CSR_MINSTRET) begin
            minstret[31:0] <= csr_wdata_c[31:0];
        end else if (csr_we_c && wb_csr_addr == CSR_MINSTRETH) begin
            minstret[63:32] <= csr_wdata_c[31:0];
        end else if (wb_valid) begin
            minstret <= minstret + 64'd1;
        end
    end

`ifdef COMMIT_TRACE_EN
    trace_entry_t entry;

    always_comb begin
        entry       = '0;
        entry.pc    = wb_pc_out[31:0];
        entry.instr = wb_instr;
        entry.rd    = wb_reg_file_rd;
        entry.wdata = rf_wdata_c[31:0];
        entry.we    = rf_we_c;
    end

    commit_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_trace_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (wb_valid),
        .push_data  (entry),
        .pop_ready  (trace_ready),
        .head_valid (trace_valid),
        .head_data  (trace_data),
        .overflow   (trace_overflow)
    );
`else
    logic unused_trace;
    assign unused_trace   = ^{trace_ready, wb_instr, (TRACE_DEPTH != 0)};
    assign trace_valid    = 1'b0;
    assign trace_data     = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule
